// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencer for the rv32 five-stage core.
//
// Turns hazard-manager requests (stall_req, false_path) and memory handshakes
// (imem_valid, dmem_busy) into per-stage register enables, NOP insertion and
// squash controls. It also tracks one valid bit per stage.
//
// Parameters
//   STALL_CYCLES : bubbles inserted per load-use stall request (1..7)
//   FLUSH_CYCLES : extra squashed fetch cycles after a redirect (0..3)
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   stall_req           : load-use hazard
//   false_path          : taken branch/jump resolved in E
//   imem_valid          : fetch data valid this cycle
//   dmem_busy           : A-stage data memory access not complete
//   en_pc, en_fd, en_de, en_ea, en_aw : PC and stage register enables
//   flush_fd, bubble_de, bubble_aw    : load NOP into F->D, D->E, A->W
//   valid_vec           : stage valid bits {W,A,E,D,F}
//   retire              : valid instruction leaving W this cycle
//   stall_cnt, flush_cnt, retire_cnt : performance counters, present only
//                         when the macro PIPE_CTRL_PERF_EN is defined
module pipe_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_req,
  input  logic       false_path,
  input  logic       imem_valid,
  input  logic       dmem_busy,
  output logic       en_pc,
  output logic       en_fd,
  output logic       en_de,
  output logic       en_ea,
  output logic       en_aw,
  output logic       flush_fd,
  output logic       bubble_de,
  output logic       bubble_aw,
  output logic [4:0] valid_vec,
  output logic       retire
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] retire_cnt
`endif
);

  typedef enum logic [1:0] {RUN, LSTALL, FLUSH, MWAIT} state_t;

  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;       // state to resume once dmem_busy drops
  state_t     eff;                // state whose behaviour applies this cycle
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] vld_q, vld_d;       // registered valid bits {W,A,E,D}
  logic       f_bit;
  logic       fp_acc;             // a false_path was acted on this cycle

  always_comb begin
    en_pc     = 1'b0;
    en_fd     = 1'b0;
    en_de     = 1'b0;
    en_ea     = 1'b0;
    en_aw     = 1'b0;
    flush_fd  = 1'b0;
    bubble_de = 1'b0;
    bubble_aw = 1'b0;
    fp_acc    = 1'b0;
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    // Leaving MWAIT takes effect in the same cycle dmem_busy drops.
    eff       = (state_q == MWAIT) ? ret_q : state_q;

    if (rst) begin
      state_d = RUN;
      ret_d   = RUN;
      cnt_d   = 3'd0;
    end else if (dmem_busy) begin
      // Freeze F..A; W takes a NOP. cnt is untouched so LSTALL/FLUSH resume.
      en_aw     = 1'b1;
      bubble_aw = 1'b1;
      state_d   = MWAIT;
      if (state_q != MWAIT) ret_d = state_q;
    end else begin
      state_d = eff;
      ret_d   = RUN;
      case (eff)
        LSTALL: begin
          bubble_de = 1'b1;
          en_de     = 1'b1;
          en_ea     = 1'b1;
          en_aw     = 1'b1;
          cnt_d     = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = RUN;
        end
        FLUSH: begin
          {en_pc, en_fd, en_de, en_ea, en_aw} = 5'b11111;
          flush_fd = 1'b1;
          if (false_path) begin
            bubble_de = 1'b1;
            fp_acc    = 1'b1;
            cnt_d     = FLUSH_INIT;
          end else begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) state_d = RUN;
          end
        end
        default: begin
          {en_pc, en_fd, en_de, en_ea, en_aw} = 5'b11111;
          if (false_path) begin
            // Squash the two wrong-path instructions in F and D; a
            // simultaneous stall_req refers to a squashed instruction.
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
            fp_acc    = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end else if (stall_req) begin
            en_pc     = 1'b0;
            en_fd     = 1'b0;
            bubble_de = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = LSTALL;
              cnt_d   = STALL_INIT;
            end
          end
        end
      endcase
    end

    f_bit = imem_valid & ~flush_fd;
    vld_d[0] = flush_fd  ? 1'b0 : (en_fd ? f_bit    : vld_q[0]);
    vld_d[1] = bubble_de ? 1'b0 : (en_de ? vld_q[0] : vld_q[1]);
    vld_d[2] = en_ea ? vld_q[1] : vld_q[2];
    vld_d[3] = bubble_aw ? 1'b0 : (en_aw ? vld_q[2] : vld_q[3]);
    if (rst) vld_d = 4'd0;
  end

  assign valid_vec = {vld_q, f_bit};
  assign retire    = vld_q[3] & en_aw;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ret_q   <= ret_d;
    cnt_q   <= cnt_d;
    vld_q   <= vld_d;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q  + {31'd0, ~en_pc};
    flush_cnt_d  = flush_cnt_q  + {31'd0, fp_acc};
    retire_cnt_d = retire_cnt_q + {31'd0, retire};
    if (rst) begin
      stall_cnt_d  = 32'd0;
      flush_cnt_d  = 32'd0;
      retire_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q  <= stall_cnt_d;
    flush_cnt_q  <= flush_cnt_d;
    retire_cnt_q <= retire_cnt_d;
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  logic unused_fp_acc;
  assign unused_fp_acc = fp_acc;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst, stall_req, false_path, imem_valid, dmem_busy;
  logic       en_pc, en_fd, en_de, en_ea, en_aw;
  logic       flush_fd, bubble_de, bubble_aw, retire;
  logic [4:0] valid_vec;
  logic [7:0] ctl;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, retire_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // {en_pc,en_fd,en_de,en_ea,en_aw,flush_fd,bubble_de,bubble_aw}
  localparam logic [7:0] ZERO = 8'b00000_000;
  localparam logic [7:0] ALL  = 8'b11111_000;
  localparam logic [7:0] STL  = 8'b00111_010;
  localparam logic [7:0] FP   = 8'b11111_110;
  localparam logic [7:0] FL   = 8'b11111_100;
  localparam logic [7:0] MW   = 8'b00001_001;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .false_path(false_path),
    .imem_valid(imem_valid), .dmem_busy(dmem_busy),
    .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_ea(en_ea), .en_aw(en_aw),
    .flush_fd(flush_fd), .bubble_de(bubble_de), .bubble_aw(bubble_aw),
    .valid_vec(valid_vec), .retire(retire)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
`endif
  );

  assign ctl = {en_pc, en_fd, en_de, en_ea, en_aw, flush_fd, bubble_de, bubble_aw};

  // stimulus word: {rst, stall_req, false_path, dmem_busy, imem_valid}
  // expected word: {ctl, valid_vec, retire}

  task automatic test_reset();
    {rst, stall_req, false_path, dmem_busy, imem_valid} = 5'b11110;
    #1;
    n_cmp++;
    if ({ctl, retire} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ctl=%b ret=%b, want ctl=%b ret=0", ctl, retire, ZERO);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({ctl, valid_vec, retire} !== {ZERO, 5'b00000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got ctl=%b vld=%b ret=%b, want ctl=%b vld=00000 ret=0",
               ctl, valid_vec, retire, ZERO);
    end
    @(posedge clk); #1;
    {rst, stall_req, false_path, dmem_busy, imem_valid} = 5'b00000;
    #1;
    n_cmp++;
    if ({ctl, valid_vec, retire} !== {ALL, 5'b00000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_release: got ctl=%b vld=%b ret=%b, want ctl=%b vld=00000 ret=0",
               ctl, valid_vec, retire, ALL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [13:0] ex [5] = '{{ALL, 5'b00001, 1'b0}, {ALL, 5'b00011, 1'b0},
                            {ALL, 5'b00111, 1'b0}, {ALL, 5'b01111, 1'b0},
                            {ALL, 5'b11111, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      {rst, stall_req, false_path, dmem_busy, imem_valid} = 5'b00001;
      #1;
      n_cmp++;
      if ({ctl, valid_vec, retire} !== ex[i]) begin
        n_bad++;
        $display("FAIL fill[%0d]: got ctl=%b vld=%b ret=%b, want %b", i, ctl, valid_vec, retire, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [4:0]  st [4] = '{5'b01001, 5'b00001, 5'b00001, 5'b00001};
    logic [13:0] ex [4] = '{{STL, 5'b11111, 1'b1}, {STL, 5'b11011, 1'b1},
                            {ALL, 5'b10011, 1'b1}, {ALL, 5'b00111, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      {rst, stall_req, false_path, dmem_busy, imem_valid} = st[i];
      #1;
      n_cmp++;
      if ({ctl, valid_vec, retire} !== ex[i]) begin
        n_bad++;
        $display("FAIL load_use[%0d]: got ctl=%b vld=%b ret=%b, want %b", i, ctl, valid_vec, retire, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    logic [4:0]  st [4] = '{5'b01101, 5'b00001, 5'b00001, 5'b00001};
    logic [13:0] ex [4] = '{{FP, 5'b01110, 1'b0}, {FL, 5'b11000, 1'b1},
                            {ALL, 5'b10001, 1'b1}, {ALL, 5'b00011, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      {rst, stall_req, false_path, dmem_busy, imem_valid} = st[i];
      #1;
      n_cmp++;
      if ({ctl, valid_vec, retire} !== ex[i]) begin
        n_bad++;
        $display("FAIL redirect[%0d]: got ctl=%b vld=%b ret=%b, want %b", i, ctl, valid_vec, retire, ex[i]);
      end
`ifdef PIPE_CTRL_PERF_EN
      if (i == 1) begin
        n_cmp++;
        if (flush_cnt !== 32'd1) begin
          n_bad++;
          $display("FAIL redirect_flush_cnt: got %0d, want 1", flush_cnt);
        end
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mwait_in_stall();
    logic [4:0]  st [6] = '{5'b01001, 5'b00011, 5'b00011, 5'b00011, 5'b00001, 5'b00001};
    logic [13:0] ex [6] = '{{STL, 5'b00111, 1'b0}, {MW, 5'b01011, 1'b0},
                            {MW, 5'b01011, 1'b0},  {MW, 5'b01011, 1'b0},
                            {STL, 5'b01011, 1'b0}, {ALL, 5'b10011, 1'b1}};
    for (int i = 0; i < 6; i++) begin
      {rst, stall_req, false_path, dmem_busy, imem_valid} = st[i];
      #1;
      n_cmp++;
      if ({ctl, valid_vec, retire} !== ex[i]) begin
        n_bad++;
        $display("FAIL mwait[%0d]: got ctl=%b vld=%b ret=%b, want %b", i, ctl, valid_vec, retire, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_flush();
    logic [4:0]  st [3] = '{5'b00101, 5'b10000, 5'b00000};
    logic [13:0] ex [3] = '{{FP, 5'b00110, 1'b0}, {ZERO, 5'b01000, 1'b0},
                            {ALL, 5'b00000, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      {rst, stall_req, false_path, dmem_busy, imem_valid} = st[i];
      #1;
      n_cmp++;
      if ({ctl, valid_vec, retire} !== ex[i]) begin
        n_bad++;
        $display("FAIL rst_flush[%0d]: got ctl=%b vld=%b ret=%b, want %b", i, ctl, valid_vec, retire, ex[i]);
      end
`ifdef PIPE_CTRL_PERF_EN
      if (i == 2) begin
        n_cmp++;
        if ({stall_cnt, flush_cnt, retire_cnt} !== 96'd0) begin
          n_bad++;
          $display("FAIL rst_counters: got stall=%0d flush=%0d retire=%0d, want 0 0 0",
                   stall_cnt, flush_cnt, retire_cnt);
        end
      end
`endif
      @(posedge clk); #1;
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf_counters();
    for (int i = 0; i < 20; i++) begin
      if (i < 10)       {rst, stall_req, false_path, dmem_busy, imem_valid} = 5'b00001;
      else if (i == 10) {rst, stall_req, false_path, dmem_busy, imem_valid} = 5'b01000;
      else              {rst, stall_req, false_path, dmem_busy, imem_valid} = 5'b00000;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (retire_cnt !== 32'd10) begin
      n_bad++;
      $display("FAIL perf_retire_cnt: got %0d, want 10", retire_cnt);
    end
    n_cmp++;
    if (stall_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL perf_stall_cnt: got %0d, want 2", stall_cnt);
    end
    n_cmp++;
    if (flush_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_flush_cnt: got %0d, want 0", flush_cnt);
    end
  endtask
`endif

  initial begin
    {rst, stall_req, false_path, dmem_busy, imem_valid} = 5'b10000;
    test_reset();
    test_fill();
    test_load_use();
    test_redirect();
    test_mwait_in_stall();
    test_reset_in_flush();
`ifdef PIPE_CTRL_PERF_EN
    test_perf_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
